stream_port_arbiter: RTL and testbench
======================================

Name: stream_port_arbiter

Overview:
- Shares one leaf-interface output port between NUM_REQ user-side output streams using the vld/ack handshake.
- Arbitration is round-robin with burst locking, so a requester keeps the port for up to MAX_BURST consecutive beats.
- Each forwarded word carries the index of its source stream, so several HLS outputs can use one interface port slot.
- Sits between user-kernel output streams and the leaf_interface user2interface port.

Parameters:
- PAYLOAD_BITS, 32: data width of each stream.
- NUM_REQ, 2: number of requesting streams (2..8).
- REQ_BITS, 1: width of the source index; must satisfy 2**REQ_BITS >= NUM_REQ.
- MAX_BURST, 16: maximum beats per grant (1..256).

Ports:
- clk_user  in  1  user clock; all logic is on this clock.
- reset  in  1  asynchronous, active-low reset.
- din_req  in  NUM_REQ*PAYLOAD_BITS  request data; stream i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_req  in  NUM_REQ  per-stream valid.
- ack_req  out  NUM_REQ  per-stream ack.
- dout  out  PAYLOAD_BITS  word to the interface.
- vld_out  out  1  dout valid.
- ack_in  in  1  interface accepts dout.
- src_id  out  REQ_BITS  source stream index of dout.

Behaviour:
- Transfer rule: a transfer happens on any cycle where valid and ack are both high. Producers hold data/valid until acked. Each side may see multiple back-to-back transfers.
- Reset: async assert clears the following. Outputs: vld_out=0, dout=0, src_id=0, ack_req=0. Internal: FSM=IDLE, grant=0, beat_cnt=0, last_grant=NUM_REQ-1. Any word in the output register is discarded. Deassertion is synchronised externally.
- Output register: one entry (dout, src_id, vld_out).
  - can_load = !vld_out | ack_in.
  - On a load, vld_out=1 the next cycle.
  - On ack_in without a load, vld_out=0 the next cycle.
- FSM state IDLE:
  - ack_req=0.
  - If any vld_req bit is set, choose the first set bit searching last_grant+1, +2, ... with wrap modulo NUM_REQ.
  - Register that bit into grant, clear beat_cnt, go to GRANT.
  - If no vld_req bit is set, stay in IDLE.
- FSM state GRANT:
  - ack_req[grant] = vld_req[grant] & can_load. Every other ack_req bit is 0. This path is combinational from ack_in.
  - Each beat loads dout=din_req[grant], src_id=grant, and increments beat_cnt.
  - Release when either condition holds: (a) a beat is taken with beat_cnt==MAX_BURST-1, or (b) vld_req[grant]==0.
  - On release: last_grant=grant, go to IDLE.
  - If vld_req[grant]=1 but can_load=0 (backpressure), hold the grant and do not release.
- Latency: vld_req rises in cycle 0 while in IDLE → ack_req in cycle 1 → vld_out in cycle 2. With ack_in held high, a grant sustains one beat per cycle.
- Switch overhead: every release costs exactly one IDLE cycle.
- Boundary conditions:
  - MAX_BURST=1: exactly one beat per grant.
  - Requests arriving in the same cycle: resolved by the round-robin pointer only; there is no fixed priority.
  - A requester dropping vld mid-burst loses the grant.
  - A requester never acked while not granted must hold its data unchanged.
  - beat_cnt is $clog2(MAX_BURST+1) bits wide and never wraps.
- Ordering: words from one requester are never reordered. No word is duplicated or dropped except on reset.

Optional Feature:
- Macro: STREAM_ARB_STATS_EN.
- When defined, adds two outputs:
  - beat_count: NUM_REQ*32 bits, per-requester 32-bit counters of beats transferred.
  - stall_count: 32 bits, counts cycles with vld_out & !ack_in.
- All counters wrap at 2**32, reset to 0, and update on the cycle the event occurs.
- When undefined: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset mid-burst: assert reset while vld_out=1 and grant=1 → vld_out, ack_req, and src_id go to 0 immediately. After release, the first grant goes to stream 0.
- Single stream: stream 0 sends 0x11,0x22,0x33 with ack_in=1 → dout shows 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first vld, src_id=0.
- Contention: both streams valid continuously, MAX_BURST=4, ack_in=1 → src_id sequence 0,0,0,0 (one gap cycle) 1,1,1,1 (gap) 0..., no lost words.
- Backpressure: ack_in=0 for 5 cycles mid-burst → ack_req[grant]=0, dout stable, no release. After ack_in=1, the burst resumes with correct beat_cnt.
- Early release: stream 1 drops vld after 2 of 16 beats while stream 0 waits → grant moves to stream 0 after one IDLE cycle.
- With STREAM_ARB_STATS_EN: run contention for 40 beats → beat_count = 20 per stream. stall_count equals the cycles driven with ack_in=0 while vld_out=1.

Source files
------------

// File: rtl/stream_port_arbiter.sv
// ----------------------------------------------------------------------------
// stream_port_arbiter
//
// Shares one leaf-interface output port between NUM_REQ user-side output
// streams. Round-robin arbitration with burst locking: a granted requester
// keeps the port for up to MAX_BURST beats, and every release costs one IDLE
// cycle. Each forwarded word carries the index of its source stream in src_id.
//
// Ports (all on clk_user):
//   clk_user     in   user clock
//   reset        in   asynchronous active-low reset
//   din_req      in   NUM_REQ*PAYLOAD_BITS, stream i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_req      in   NUM_REQ per-stream valid
//   ack_req      out  NUM_REQ per-stream ack (combinational from ack_in)
//   dout         out  PAYLOAD_BITS registered word to the interface
//   vld_out      out  dout valid
//   ack_in       in   interface accepts dout
//   src_id       out  REQ_BITS source index of dout
//
// Optional feature, macro STREAM_ARB_STATS_EN:
//   beat_count   out  NUM_REQ*32 per-requester beat counters (wrapping)
//   stall_count  out  32, cycles with vld_out & !ack_in (wrapping)
// ----------------------------------------------------------------------------
module stream_port_arbiter #(
   parameter int PAYLOAD_BITS = 32,
   parameter int NUM_REQ      = 2,
   parameter int REQ_BITS     = 1,
   parameter int MAX_BURST    = 16
) (
   input  logic                            clk_user,
   input  logic                            reset,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
   input  logic [NUM_REQ-1:0]              vld_req,
   output logic [NUM_REQ-1:0]              ack_req,
   output logic [PAYLOAD_BITS-1:0]         dout,
   output logic                            vld_out,
   input  logic                            ack_in,
   output logic [REQ_BITS-1:0]             src_id
`ifdef STREAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]           beat_count,
   output logic [31:0]                     stall_count
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [REQ_BITS-1:0]      grant_q, grant_d;
   logic [REQ_BITS-1:0]      last_grant_q, last_grant_d;
   logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
   logic [PAYLOAD_BITS-1:0]  dout_q, dout_d;
   logic [REQ_BITS-1:0]      src_id_q, src_id_d;
   logic                     vld_out_q, vld_out_d;

   logic                     can_load_s;
   logic                     beat_s;
   logic [NUM_REQ-1:0]       ack_req_s;
   logic [NUM_REQ-1:0]       grant_oh_s;
   logic                     sel_vld_s;
   logic [PAYLOAD_BITS-1:0]  sel_din_s;
   logic [REQ_BITS-1:0]      rr_pick_s;
   logic                     rr_found_s;
   logic                     rr_hit_s;
   int                       rr_dist_s;
   int                       rr_best_s;

   assign can_load_s = !vld_out_q || ack_in;

   // Decode the grant into a one-hot mask and select the granted stream's valid/data.
   always_comb begin
      grant_oh_s = '0;
      sel_din_s  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         grant_oh_s[j] = (grant_q == REQ_BITS'(j));
         sel_din_s     = sel_din_s |
                         (din_req[j*PAYLOAD_BITS +: PAYLOAD_BITS] & {PAYLOAD_BITS{grant_oh_s[j]}});
      end
      sel_vld_s = |(vld_req & grant_oh_s);
   end

   // Round-robin pick: the set request at the smallest distance after last_grant wins.
   always_comb begin
      rr_pick_s  = '0;
      rr_found_s = 1'b0;
      rr_hit_s   = 1'b0;
      rr_best_s  = NUM_REQ;
      rr_dist_s  = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         rr_dist_s  = j - int'(last_grant_q) - 1;
         rr_dist_s  = (rr_dist_s < 0) ? rr_dist_s + NUM_REQ : rr_dist_s;
         rr_hit_s   = vld_req[j] && (rr_dist_s < rr_best_s);
         rr_best_s  = rr_hit_s ? rr_dist_s : rr_best_s;
         rr_pick_s  = rr_hit_s ? REQ_BITS'(j) : rr_pick_s;
         rr_found_s = rr_found_s | rr_hit_s;
      end
   end

   // Arbiter FSM next state, beat handshake and output-register load.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      dout_d       = dout_q;
      src_id_d     = src_id_q;
      // An accepted word without a replacement leaves the register empty.
      vld_out_d    = vld_out_q && !ack_in;
      beat_s       = 1'b0;
      ack_req_s    = '0;
      case (state_q)
         ST_IDLE: begin
            if (rr_found_s) begin
               grant_d    = rr_pick_s;
               beat_cnt_d = '0;
               state_d    = ST_GRANT;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_GRANT: begin
            beat_s    = sel_vld_s && can_load_s;
            ack_req_s = grant_oh_s & {NUM_REQ{beat_s}};
            if (beat_s) begin
               dout_d     = sel_din_s;
               src_id_d   = grant_q;
               vld_out_d  = 1'b1;
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
            // Backpressure with vld still high holds the grant: neither term is true.
            if ((beat_s && (beat_cnt_q == CNT_W'(MAX_BURST - 1))) || !sel_vld_s) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end else begin
               state_d      = ST_GRANT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, grant bookkeeping and output register.
   always_ff @(posedge clk_user or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= REQ_BITS'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
         dout_q       <= '0;
         src_id_q     <= '0;
         vld_out_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         dout_q       <= dout_d;
         src_id_q     <= src_id_d;
         vld_out_q    <= vld_out_d;
      end
   end

   assign ack_req = ack_req_s;
   assign dout    = dout_q;
   assign vld_out = vld_out_q;
   assign src_id  = src_id_q;

`ifdef STREAM_ARB_STATS_EN
   logic [31:0] stat_beat_q [NUM_REQ];
   logic [31:0] stat_stall_q;

   // Per-requester beat counters and output stall counter, wrapping at 2**32.
   always_ff @(posedge clk_user or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            stat_beat_q[j] <= 32'd0;
         end
         stat_stall_q <= 32'd0;
      end else begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (ack_req_s[j]) begin
               stat_beat_q[j] <= stat_beat_q[j] + 32'd1;
            end
         end
         if (vld_out_q && !ack_in) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
      end
   end

   // Pack the counters onto the flat output bus.
   always_comb begin
      beat_count = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         beat_count[j*32 +: 32] = stat_beat_q[j];
      end
   end

   assign stall_count = stat_stall_q;
`endif

endmodule

// File: tb/tb_stream_port_arbiter.sv
// ----------------------------------------------------------------------------
// Bench for stream_port_arbiter (NUM_REQ=2, MAX_BURST=4). Producers follow the
// vld/ack protocol and emit numbered words; a per-stream FIFO scoreboard
// checks data, ordering and src_id; directed sequences check reset, latency,
// burst locking, backpressure, early release and reset mid-burst.
// ----------------------------------------------------------------------------
module tb_stream_port_arbiter;

   localparam int PB = 32;
   localparam int NR = 2;
   localparam int RB = 1;
   localparam int MB = 4;

   logic             clk_user = 1'b0;
   logic             reset;
   logic [NR*PB-1:0] din_req;
   logic [NR-1:0]    vld_req;
   logic [NR-1:0]    ack_req;
   logic [PB-1:0]    dout;
   logic             vld_out;
   logic             ack_in;
   logic [RB-1:0]    src_id;
`ifdef STREAM_ARB_STATS_EN
   logic [NR*32-1:0] beat_count;
   logic [31:0]      stall_count;
`endif

   stream_port_arbiter #(
      .PAYLOAD_BITS (PB),
      .NUM_REQ      (NR),
      .REQ_BITS     (RB),
      .MAX_BURST    (MB)
   ) dut (
      .clk_user (clk_user),
      .reset    (reset),
      .din_req  (din_req),
      .vld_req  (vld_req),
      .ack_req  (ack_req),
      .dout     (dout),
      .vld_out  (vld_out),
      .ack_in   (ack_in),
      .src_id   (src_id)
`ifdef STREAM_ARB_STATS_EN
      ,
      .beat_count  (beat_count),
      .stall_count (stall_count)
`endif
   );

   always #5 clk_user = ~clk_user;

   int n_cmp = 0;
   int n_bad = 0;

   int          seq    [NR];
   int          lim    [NR];
   int          wait_b [NR];
   int          beats_tb [NR];
   int          stall_tb;
   logic [NR-1:0] want;
   logic        ack_drv;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   logic [NR-1:0] s_ack_req;
   logic          s_vld_out;
   logic [PB-1:0] s_dout;
   logic [RB-1:0] s_src;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word(input int i, input int s);
      return (32'(i) << 28) | ((32'h11 * 32'(s + 1)) & 32'h0FFF_FFFF);
   endfunction

   // One cycle: sample at the negedge, score, then drive producers after the posedge.
   task automatic step();
      logic [NR-1:0] fin;
      logic          fout;
      logic [31:0]   exp_w;
      @(negedge clk_user);
      s_ack_req = ack_req;
      s_vld_out = vld_out;
      s_dout    = dout;
      s_src     = src_id;
      fin  = vld_req & ack_req;
      fout = vld_out & ack_in;
      check_eq("ack_onehot", 64'($countones(ack_req) <= 1), 64'(1));
      check_eq("ack_without_vld", 64'(ack_req & ~vld_req), 64'(0));
      if (vld_out && !ack_in) stall_tb++;
      for (int i = 0; i < NR; i++) begin
         if (fin[i]) begin
            beats_tb[i]++;
            if (i == 0) q0.push_back(din_req[i*PB +: PB]);
            else        q1.push_back(din_req[i*PB +: PB]);
         end
      end
      if (fout) begin
         if (src_id == 1'b0) begin
            check_eq("sb_nonempty0", 64'(q0.size() > 0), 64'(1));
            if (q0.size() > 0) begin
               exp_w = q0.pop_front();
               check_eq("sb_data0", 64'(dout), 64'(exp_w));
            end
         end else begin
            check_eq("sb_nonempty1", 64'(q1.size() > 0), 64'(1));
            if (q1.size() > 0) begin
               exp_w = q1.pop_front();
               check_eq("sb_data1", 64'(dout), 64'(exp_w));
            end
         end
      end
      // A waiting requester may see at most one full burst of the other stream.
      for (int j = 0; j < NR; j++) begin
         wait_b[j] = (vld_req[j] && !fin[j]) ? wait_b[j] + $countones(fin & ~(2'(1) << j)) : 0;
         check_eq("rr_wait_bound", 64'(wait_b[j] > MB), 64'(0));
      end
      @(posedge clk_user);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (fin[i]) seq[i]++;
         if (!vld_req[i] || fin[i]) begin
            vld_req[i] = want[i] && (seq[i] < lim[i]);
            din_req[i*PB +: PB] = word(i, seq[i]);
         end
      end
      ack_in = ack_drv;
   endtask

   task automatic chk_samp(input string tag, input logic [NR-1:0] ea, input int ev,
                           input int es, input int ew);
      check_eq({tag, "_ack"}, 64'(s_ack_req), 64'(ea));
      if (ev >= 0) check_eq({tag, "_vld"}, 64'(s_vld_out), 64'(ev));
      if (es >= 0) check_eq({tag, "_src"}, 64'(s_src), 64'(es));
      if (ew >= 0) check_eq({tag, "_dout"}, 64'(s_dout), 64'(word(es, ew)));
   endtask

   task automatic drain(input int n);
      want    = '0;
      ack_drv = 1'b1;
      repeat (n) step();
   endtask

   localparam logic [1:0] C_ACK [6]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
   localparam int         C_VLD [6]  = '{0, 0, 1, 1, 1, 0};
   localparam int         C_W   [6]  = '{-1, -1, 0, 1, 2, -1};
   localparam logic [1:0] D_ACK [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                         2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
   localparam int         D_VLD [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   localparam int         D_W   [12] = '{-1, -1, 0, 1, 1, 1, 1, 1, 1, 2, 3, -1};
   localparam logic [1:0] E_ACK [7]  = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
   localparam int         E_VLD [7]  = '{0, 0, 1, 1, 0, 0, 1};
   localparam int         E_SRC [7]  = '{-1, -1, 1, 1, -1, -1, 0};

   initial begin
      reset   = 1'b0;
      din_req = '0;
      vld_req = '0;
      ack_in  = 1'b0;
      want    = '0;
      ack_drv = 1'b1;
      stall_tb = 0;
      for (int i = 0; i < NR; i++) begin
         seq[i] = 0; lim[i] = 1 << 30; wait_b[i] = 0; beats_tb[i] = 0;
      end

      // Reset state
      repeat (2) @(posedge clk_user);
      #1;
      check_eq("rst_vld_out", 64'(vld_out), 64'(0));
      check_eq("rst_dout",    64'(dout),    64'(0));
      check_eq("rst_src_id",  64'(src_id),  64'(0));
      check_eq("rst_ack_req", 64'(ack_req), 64'(0));
      reset  = 1'b1;
      ack_in = 1'b1;
      step();

      // Single stream: 0x11, 0x22, 0x33, first word two cycles after vld
      seq[0] = 0; lim[0] = 3; want = 2'b01;
      step();
      for (int c = 0; c < 6; c++) begin
         step();
         chk_samp("single", C_ACK[c], C_VLD[c], (C_W[c] >= 0) ? 0 : -1, C_W[c]);
      end
      drain(4);

      // Backpressure for five cycles mid-burst, then the burst completes at 4 beats
      seq[0] = 0; lim[0] = 1 << 30; want = 2'b01;
      step();
      for (int c = 0; c < 12; c++) begin
         ack_drv = !((c + 1 >= 3) && (c + 1 <= 7));
         step();
         chk_samp("bp", D_ACK[c], D_VLD[c], (D_W[c] >= 0) ? 0 : -1, D_W[c]);
      end
      drain(8);

      // Early release: stream 1 leaves after 2 beats, stream 0 follows after one IDLE
      seq[1] = 0; lim[1] = 2; want = 2'b11;
      step();
      for (int c = 0; c < 7; c++) begin
         step();
         chk_samp("early", E_ACK[c], E_VLD[c], E_SRC[c], -1);
      end
      drain(8);

      // Reset mid-burst while stream 1 owns the output register
      lim[1] = 1 << 30; want = 2'b10;
      step();
      for (int c = 0; c < 4; c++) step();
      check_eq("pre_rst_vld", 64'(s_vld_out), 64'(1));
      check_eq("pre_rst_src", 64'(s_src),     64'(1));
      #1;
      reset = 1'b0;
      #1;
      check_eq("midrst_vld_out", 64'(vld_out), 64'(0));
      check_eq("midrst_ack_req", 64'(ack_req), 64'(0));
      check_eq("midrst_src_id",  64'(src_id),  64'(0));
      vld_req = '0; want = '0;
      q0.delete(); q1.delete();
      stall_tb = 0;
      for (int i = 0; i < NR; i++) begin wait_b[i] = 0; beats_tb[i] = 0; end
      @(posedge clk_user);
      #1;
      reset = 1'b1;
      step();

      // Contention: 20 beats per stream, bursts of 4 separated by one gap
      for (int i = 0; i < NR; i++) lim[i] = seq[i] + 20;
      want = 2'b11;
      step();
      for (int c = 0; c < 56; c++) begin
         step();
         if (c == 1) check_eq("first_grant_after_rst", 64'(s_ack_req), 64'(2'b01));
         if (c >= 2 && c <= 51) begin
            check_eq("cont_vld", 64'(s_vld_out), 64'(((c - 2) % 10) % 5 != 4));
            if (((c - 2) % 10) % 5 != 4)
               check_eq("cont_src", 64'(s_src), 64'(((c - 2) % 10) >= 5));
         end
      end
      drain(4);
`ifdef STREAM_ARB_STATS_EN
      check_eq("stat_beats0", 64'(beat_count[31:0]),  64'(20));
      check_eq("stat_beats1", 64'(beat_count[63:32]), 64'(20));
      check_eq("stat_stall_cont", 64'(stall_count), 64'(stall_tb));
`endif

      // Randomized traffic against the scoreboard
      for (int i = 0; i < NR; i++) lim[i] = 1 << 30;
      for (int c = 0; c < 800; c++) begin
         want    = 2'($urandom_range(0, 3));
         ack_drv = ($urandom_range(0, 3) != 0);
         step();
      end
      drain(20);
      check_eq("sb_drained0", 64'(q0.size()), 64'(0));
      check_eq("sb_drained1", 64'(q1.size()), 64'(0));
`ifdef STREAM_ARB_STATS_EN
      check_eq("stat_beats0_rand", 64'(beat_count[31:0]),  64'(beats_tb[0]));
      check_eq("stat_beats1_rand", 64'(beat_count[63:32]), 64'(beats_tb[1]));
      check_eq("stat_stall_rand",  64'(stall_count),       64'(stall_tb));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
